// File: rtl/ysyx_24080014_lsu.sv
// ysyx_24080014_lsu: multicycle load/store unit between EXU and the data-memory port.
// One memory instruction is in flight at a time. The request is word-aligned,
// store data is lane-replicated with a byte mask, and load data is aligned and
// extended before being handed to WBU.
//
// Optional build macro: YSYX_24080014_LSU_MISALIGN_CHECK_EN
//   defined   : H with addr[0]=1 or W with addr[1:0]!=0 faults without a memory access
//   undefined : misaligned low offset bits are ignored (H uses addr[1], W the aligned word)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a new instruction from EXU
// REQ    | mem_req_valid held with stable fields until mem_req_ready
// WAIT   | request accepted, waiting for the one-cycle response pulse
// DONE   | out_valid held with stable result until out_ready

module ysyx_24080014_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [4:0]        in_rd,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wmask,

  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_rdata,
  input  logic              mem_rsp_err,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_rdata,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  output logic              out_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state;

  // Attributes of the accepted instruction needed when the response returns
  logic        lat_load;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;

  // Decode of the incoming request
  logic [1:0]  in_off;
  logic        f3_known;
  logic        misaligned;
  logic        req_ok;
  logic [3:0]  st_wmask;
  logic [31:0] st_wdata;

  // Load extraction from the response word
  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;
  logic [31:0] ld_data;

  assign in_off   = in_addr[1:0];
  assign in_ready = (state == S_IDLE);

`ifdef YSYX_24080014_LSU_MISALIGN_CHECK_EN
  // H/HU need an even offset, W needs offset 0
  assign misaligned = ((in_funct3[1:0] == 2'b01) && in_off[0]) ||
                      ((in_funct3[1:0] == 2'b10) && (in_off != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Request legality: one op type, known width, no unsigned stores, alignment if enabled
  always_comb begin
    f3_known = (in_funct3 == F3_B)  || (in_funct3 == F3_H)  || (in_funct3 == F3_W) ||
               (in_funct3 == F3_BU) || (in_funct3 == F3_HU);
    req_ok   = (in_load != in_store) && f3_known &&
               !(in_store && in_funct3[2]) && !misaligned;
  end

  // Store lane mask and replicated data; width codes already known to be B/H/W here
  always_comb begin
    st_wmask = 4'b1111;
    st_wdata = in_wdata;
    case (in_funct3[1:0])
      2'b00: begin
        st_wmask = 4'b0001 << in_off;
        st_wdata = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        st_wmask = 4'b0011 << {in_off[1], 1'b0};
        st_wdata = {2{in_wdata[15:0]}};
      end
      default: begin
        st_wmask = 4'b1111;
        st_wdata = in_wdata;
      end
    endcase
  end

  // Select the addressed byte/halfword from the response and extend it
  always_comb begin
    rsp_byte = mem_rsp_rdata[7:0];
    case (lat_off)
      2'd0:    rsp_byte = mem_rsp_rdata[7:0];
      2'd1:    rsp_byte = mem_rsp_rdata[15:8];
      2'd2:    rsp_byte = mem_rsp_rdata[23:16];
      default: rsp_byte = mem_rsp_rdata[31:24];
    endcase
    rsp_half = lat_off[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
    case (lat_funct3)
      F3_B:    ld_data = {{24{rsp_byte[7]}}, rsp_byte};
      F3_BU:   ld_data = {24'd0, rsp_byte};
      F3_H:    ld_data = {{16{rsp_half[15]}}, rsp_half};
      F3_HU:   ld_data = {16'd0, rsp_half};
      default: ld_data = mem_rsp_rdata;
    endcase
  end

  // Control FSM with registered request and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      lat_load      <= 1'b0;
      lat_funct3    <= 3'd0;
      lat_off       <= 2'd0;
      mem_req_valid <= 1'b0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= 32'd0;
      mem_req_wmask <= 4'd0;
      out_valid     <= 1'b0;
      out_rdata     <= 32'd0;
      out_rd        <= 5'd0;
      out_wen       <= 1'b0;
      out_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            lat_load   <= in_load;
            lat_funct3 <= in_funct3;
            lat_off    <= in_off;
            out_rd     <= in_rd;
            out_rdata  <= 32'd0;
            out_wen    <= 1'b0;
            if (req_ok) begin
              mem_req_valid <= 1'b1;
              mem_req_wen   <= in_store;
              mem_req_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
              mem_req_wdata <= in_store ? st_wdata : 32'd0;
              mem_req_wmask <= in_store ? st_wmask : 4'd0;
              out_err       <= 1'b0;
              state         <= S_REQ;
            end else begin
              // Illegal request: report the fault without touching memory
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            out_valid <= 1'b1;
            state     <= S_DONE;
            if (mem_rsp_err) begin
              out_err   <= 1'b1;
              out_rdata <= 32'd0;
              out_wen   <= 1'b0;
            end else begin
              out_err   <= 1'b0;
              out_rdata <= lat_load ? ld_data : 32'd0;
              out_wen   <= lat_load && (out_rd != 5'd0);
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// Self-checking bench for ysyx_24080014_lsu: directed test-plan cases, reset
// behaviour and randomized transactions against an arithmetic reference model.
// Honours YSYX_24080014_LSU_MISALIGN_CHECK_EN when the design is built with it.

module tb_ysyx_24080014_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_load = 1'b0;
  logic        in_store = 1'b0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [31:0] in_addr = 32'd0;
  logic [31:0] in_wdata = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = 32'd0;
  logic        mem_rsp_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_err;

  int checks = 0;
  int errors = 0;

`ifdef YSYX_24080014_LSU_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  // Values seen during the most recent transaction, for directed constant checks
  logic [31:0] last_addr, last_wdata, last_rdata;
  logic [3:0]  last_wmask;
  logic        last_wen, last_err, last_req_seen;

  ysyx_24080014_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_store(in_store), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_rd(out_rd), .out_wen(out_wen), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_legal(input bit ld, input bit st, input int f3, input int off);
    bit ok;
    bit mis;
    ok = (ld != st);
    if (!(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) ok = 1'b0;
    if (st && f3 >= 4) ok = 1'b0;
    mis = ((f3 == 1 || f3 == 5) && (off % 2 == 1)) || (f3 == 2 && off != 0);
    if (MIS_EN && mis) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [3:0] model_mask(input int f3, input int off);
    int m;
    if (f3 == 0)      m = 1 << off;
    else if (f3 == 1) m = 3 << (2 * (off / 2));
    else              m = 15;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input int f3, input logic [31:0] wd);
    if (f3 == 0)      return (wd % 256) * 32'h0101_0101;
    else if (f3 == 1) return (wd % 65536) * 32'h0001_0001;
    else              return wd;
  endfunction

  function automatic logic [31:0] model_load(input int f3, input int off, input logic [31:0] rsp);
    logic [31:0] v;
    if (f3 == 0 || f3 == 4) begin
      v = (rsp >> (8 * off)) % 256;
      if (f3 == 0 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (f3 == 1 || f3 == 5) begin
      v = (rsp >> (16 * (off / 2))) % 65536;
      if (f3 == 1 && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rsp;
    end
    return v;
  endfunction

  // ---------------- one complete transaction ----------------
  task automatic do_txn(input bit ld, input bit st, input int f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rsp,
                        input bit rerr, input int req_stall, input int rsp_delay, input int out_stall);
    int          off;
    bit          legal;
    logic [31:0] e_rdata;
    logic        e_err, e_wen;
    logic [3:0]  e_mask;
    off   = int'(addr[1:0]);
    legal = model_legal(ld, st, f3, off);
    e_mask = st ? model_mask(f3, off) : 4'd0;
    if (!legal || rerr) begin
      e_err = 1'b1; e_rdata = 32'd0; e_wen = 1'b0;
    end else begin
      e_err = 1'b0;
      e_rdata = ld ? model_load(f3, off, rsp) : 32'd0;
      e_wen = ld && (rd != 5'd0);
    end
    last_req_seen = 1'b0;

    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_load = ld; in_store = st; in_funct3 = f3[2:0];
    in_addr = addr; in_wdata = wd; in_rd = rd;
    step();
    in_valid = 1'b0;
    in_load = 1'($urandom); in_store = 1'($urandom); in_funct3 = 3'($urandom);
    in_addr = $urandom; in_wdata = $urandom; in_rd = 5'($urandom);

    if (legal) begin
      for (int i = 0; i <= req_stall; i++) begin
        chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("req_in_ready", {31'd0, in_ready}, 32'd0);
        chk("req_out_valid", {31'd0, out_valid}, 32'd0);
        chk("req_addr", mem_req_addr, {addr[31:2], 2'b00});
        chk("req_wen", {31'd0, mem_req_wen}, {31'd0, st});
        chk("req_wmask", {28'd0, mem_req_wmask}, {28'd0, e_mask});
        if (st) chk("req_wdata", mem_req_wdata, model_wdata(f3, wd));
        last_addr = mem_req_addr; last_wdata = mem_req_wdata;
        last_wmask = mem_req_wmask; last_req_seen = 1'b1;
        if (i == req_stall) begin
          mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
        end else begin
          mem_req_ready = 1'b0;
          mem_rsp_valid = 1'($urandom); mem_rsp_rdata = $urandom; mem_rsp_err = 1'($urandom);
        end
        step();
      end
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      for (int i = 0; i <= rsp_delay; i++) begin
        chk("wait_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("wait_out_valid", {31'd0, out_valid}, 32'd0);
        chk("wait_in_ready", {31'd0, in_ready}, 32'd0);
        if (i == rsp_delay) begin
          mem_rsp_valid = 1'b1; mem_rsp_rdata = rsp; mem_rsp_err = rerr;
        end
        step();
      end
      mem_rsp_valid = 1'b0; mem_rsp_rdata = $urandom; mem_rsp_err = 1'($urandom);
    end else begin
      chk("ill_req_valid", {31'd0, mem_req_valid}, 32'd0);
    end

    for (int i = 0; i <= out_stall; i++) begin
      chk("done_out_valid", {31'd0, out_valid}, 32'd1);
      chk("done_in_ready", {31'd0, in_ready}, 32'd0);
      chk("done_req_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("done_rdata", out_rdata, e_rdata);
      chk("done_err", {31'd0, out_err}, {31'd0, e_err});
      chk("done_wen", {31'd0, out_wen}, {31'd0, e_wen});
      chk("done_rd", {27'd0, out_rd}, {27'd0, rd});
      last_rdata = out_rdata; last_wen = out_wen; last_err = out_err;
      if (i == out_stall) begin
        out_ready = 1'b1; mem_rsp_valid = 1'b0;
      end else begin
        out_ready = 1'b0;
        mem_rsp_valid = 1'($urandom); mem_rsp_rdata = $urandom; mem_rsp_err = 1'($urandom);
      end
      step();
    end
    out_ready = 1'b0; mem_rsp_valid = 1'b0;
    chk("post_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    chk("rst_req_wdata", mem_req_wdata, 32'd0);
    chk("rst_req_wmask", {28'd0, mem_req_wmask}, 32'd0);
    chk("rst_req_wen", {31'd0, mem_req_wen}, 32'd0);
    chk("rst_out_rdata", out_rdata, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_out_wen", {31'd0, out_wen}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // SW at a half-aligned address
    do_txn(0, 1, 2, 32'h8000_0006, 32'hDEAD_BEEF, 5'd3, 32'h0, 0, 0, 0, 0);
`ifdef YSYX_24080014_LSU_MISALIGN_CHECK_EN
    chk("sw_mis_req_seen", {31'd0, last_req_seen}, 32'd0);
    chk("sw_mis_err", {31'd0, last_err}, 32'd1);
`else
    chk("sw_addr", last_addr, 32'h8000_0004);
    chk("sw_wmask", {28'd0, last_wmask}, 32'hF);
    chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
    chk("sw_wen", {31'd0, last_wen}, 32'd0);
`endif

    // SB to the top lane
    do_txn(0, 1, 0, 32'h8000_0003, 32'h0000_00A5, 5'd7, 32'h0, 0, 0, 0, 0);
    chk("sb_wmask", {28'd0, last_wmask}, 32'h8);
    chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);

    // LB / LBU from lane 1
    do_txn(1, 0, 0, 32'h8000_0001, 32'h0, 5'd5, 32'h1234_80FF, 0, 0, 0, 0);
    chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
    chk("lb_wen", {31'd0, last_wen}, 32'd1);
    do_txn(1, 0, 4, 32'h8000_0001, 32'h0, 5'd5, 32'h1234_80FF, 0, 0, 0, 0);
    chk("lbu_rdata", last_rdata, 32'h0000_0080);

    // LHU upper half into x0
    do_txn(1, 0, 5, 32'h8000_0002, 32'h0, 5'd0, 32'h8001_7FFF, 0, 0, 0, 0);
    chk("lhu_rdata", last_rdata, 32'h0000_8001);
    chk("lhu_wen", {31'd0, last_wen}, 32'd0);

    // Stalls on both handshakes with a faulting response
    do_txn(1, 0, 2, 32'h8000_0010, 32'h0, 5'd9, 32'h5555_AAAA, 1, 3, 1, 2);
    chk("stall_err", {31'd0, last_err}, 32'd1);
    chk("stall_rdata", last_rdata, 32'd0);

    // Illegal encodings: both op bits, store with unsigned width, unlisted funct3
    do_txn(1, 1, 2, 32'h0000_0040, 32'h0, 5'd4, 32'h0, 0, 0, 0, 1);
    do_txn(0, 1, 4, 32'h0000_0040, 32'h1, 5'd4, 32'h0, 0, 0, 0, 0);
    do_txn(1, 0, 3, 32'h0000_0040, 32'h0, 5'd4, 32'h0, 0, 0, 0, 0);

    // Reset while a request is pending in REQ
    in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_funct3 = 3'd2;
    in_addr = 32'h0000_0100; in_rd = 5'd12;
    step();
    in_valid = 1'b0;
    chk("rreq_req_valid", {31'd0, mem_req_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rreq_req_valid_drop", {31'd0, mem_req_valid}, 32'd0);
    chk("rreq_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rreq_out_rd", {27'd0, out_rd}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Reset during WAIT followed by a late response
    in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_funct3 = 3'd2;
    in_addr = 32'h0000_0200; in_rd = 5'd13;
    step();
    in_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rwait_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rwait_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFE_F00D; mem_rsp_err = 1'b0;
    step();
    mem_rsp_valid = 1'b0;
    step(); step();
    chk("late_out_valid", {31'd0, out_valid}, 32'd0);
    chk("late_in_ready", {31'd0, in_ready}, 32'd1);
    chk("late_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("late_out_rdata", out_rdata, 32'd0);

    // Randomized transactions
    for (int n = 0; n < 120; n++) begin
      int  r;
      bit  ld, st;
      r = $urandom_range(0, 15);
      if (r == 0)      begin ld = 1'b1; st = 1'b1; end
      else if (r == 1) begin ld = 1'b0; st = 1'b0; end
      else             begin ld = r[0]; st = !r[0]; end
      do_txn(ld, st, $urandom_range(0, 7), $urandom, $urandom, 5'($urandom),
             $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
             $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
